sample_reader: RTL and testbench



---
 rtl/oscilo_pkg.sv | 17 +
 rtl/sample_reader_if.sv | 25 ++
 rtl/sample_reader.sv | 140 ++++++++++++++
 tb/tb_sample_reader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/oscilo_pkg.sv
// Shared definitions for the oscilloscope command set and the sample reader.
package oscilo_pkg;

  localparam logic [7:0] ST_INIT        = 8'hff;
  localparam logic [7:0] ST_SAMPLE_READ = 8'h22;

  localparam int SAMPLE_ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_SEND,
    RD_WAIT,
    RD_FETCH,
    RD_FINISH
  } reader_state_t;

endpackage

// File: rtl/sample_reader_if.sv
// Sample-memory read port plus the byte handshake toward the shared UART transmitter.
interface sample_reader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) ();

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_oe;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [7:0]            tx_data;
  logic                  tx_start;
  logic                  tx_active;
  logic                  tx_done;

  modport master (
    output mem_addr, mem_oe, tx_data, tx_start,
    input  mem_data, tx_active, tx_done
  );

  modport slave (
    input  mem_addr, mem_oe, tx_data, tx_start,
    output mem_data, tx_active, tx_done
  );

endinterface

// File: rtl/sample_reader.sv
// Streams header, every sample in ascending address order, then an XOR checksum to the UART.
//
// state     | meaning
// RD_IDLE   | waiting for a rising edge on activate
// RD_SEND   | byte in tx_data, waiting for the transmitter to be free
// RD_WAIT   | byte handed off, waiting for its tx_done
// RD_FETCH  | mem_addr settled, capture sample and fold it into the checksum
// RD_FINISH | frame complete, raise done
module sample_reader
  import oscilo_pkg::*;
#(
  parameter int         DATA_WIDTH = 8,
  parameter int         ADDR_WIDTH = SAMPLE_ADDR_WIDTH,
  parameter logic [7:0] HEADER     = ST_SAMPLE_READ
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            activate,
  output logic            done,
  sample_reader_if.master bus
);

  localparam logic [ADDR_WIDTH:0] N_SAMPLES = {1'b1, {ADDR_WIDTH{1'b0}}};

  reader_state_t         state_q, state_nx;
  logic [ADDR_WIDTH:0]   index_q, index_nx;
  logic [7:0]            checksum_q, checksum_nx;
  logic                  csum_sent_q, csum_sent_nx;
  logic [7:0]            tx_data_q, tx_data_nx;
  logic                  tx_start_q, tx_start_nx;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_nx;
  logic                  mem_oe_q, mem_oe_nx;
  logic                  done_q, done_nx;
  logic                  activate_q;
  logic                  start;
  logic [7:0]            sample;

  assign start  = activate && !activate_q;
  assign sample = 8'(bus.mem_data);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RD_IDLE;
      index_q     <= '0;
      checksum_q  <= '0;
      csum_sent_q <= 1'b0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_oe_q    <= 1'b0;
      done_q      <= 1'b0;
      activate_q  <= 1'b0;
    end else begin
      state_q     <= state_nx;
      index_q     <= index_nx;
      checksum_q  <= checksum_nx;
      csum_sent_q <= csum_sent_nx;
      tx_data_q   <= tx_data_nx;
      tx_start_q  <= tx_start_nx;
      mem_addr_q  <= mem_addr_nx;
      mem_oe_q    <= mem_oe_nx;
      done_q      <= done_nx;
      activate_q  <= activate;
    end
  end

  always_comb begin
    state_nx     = state_q;
    index_nx     = index_q;
    checksum_nx  = checksum_q;
    csum_sent_nx = csum_sent_q;
    tx_data_nx   = tx_data_q;
    tx_start_nx  = 1'b0;
    mem_addr_nx  = mem_addr_q;
    mem_oe_nx    = mem_oe_q;
    done_nx      = done_q;

    if (state_q != RD_IDLE && !activate) begin
      // Abort: any byte already with the transmitter finishes on its own.
      state_nx  = RD_IDLE;
      mem_oe_nx = 1'b0;
    end else begin
      case (state_q)
        RD_IDLE: begin
          if (start) begin
            state_nx     = RD_SEND;
            tx_data_nx   = HEADER;
            checksum_nx  = '0;
            csum_sent_nx = 1'b0;
            index_nx     = '0;
            mem_oe_nx    = 1'b1;
            done_nx      = 1'b0;
          end else if (!activate) begin
            done_nx = 1'b0;
          end
        end
        RD_SEND: begin
          if (!bus.tx_active) begin
            tx_start_nx = 1'b1;
            state_nx    = RD_WAIT;
          end
        end
        RD_WAIT: begin
          // A tx_done coincident with our own tx_start belongs to an older byte.
          if (bus.tx_done && !tx_start_q) begin
            if (index_q < N_SAMPLES) begin
              mem_addr_nx = index_q[ADDR_WIDTH-1:0];
              state_nx    = RD_FETCH;
            end else if (!csum_sent_q) begin
              tx_data_nx   = checksum_q;
              csum_sent_nx = 1'b1;
              state_nx     = RD_SEND;
            end else begin
              state_nx = RD_FINISH;
            end
          end
        end
        RD_FETCH: begin
          tx_data_nx  = sample;
          checksum_nx = checksum_q ^ sample;
          index_nx    = index_q + 1'b1;
          state_nx    = RD_SEND;
        end
        RD_FINISH: begin
          done_nx   = 1'b1;
          mem_oe_nx = 1'b0;
          state_nx  = RD_IDLE;
        end
        default: state_nx = RD_IDLE;
      endcase
    end
  end

  assign done         = done_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_oe   = mem_oe_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;

endmodule

// File: tb/tb_sample_reader.sv
// Directed bench for sample_reader: memory + UART models and a frame-level reference.
module tb_sample_reader;
  import oscilo_pkg::*;

  localparam int FRAME_LEN = 258;

  logic clk = 1'b0;
  logic reset;
  logic activate;
  logic done;

  sample_reader_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

  sample_reader #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .HEADER(8'h22)) dut (
    .clk(clk), .reset(reset), .activate(activate), .done(done), .bus(bus)
  );

  always #10 clk = ~clk;

  logic [7:0] mem [0:255];
  logic [7:0] exp_frame [0:FRAME_LEN-1];
  logic [7:0] cap [0:FRAME_LEN-1];

  logic uart_busy, force_busy, tx_done_r, late_seen;
  int   uart_cnt;
  int   checks = 0, errors = 0;
  int   nbytes = 0, total_starts = 0;
  int   cyc = 0, last_done_cyc = 0;
  logic prev_start = 1'b0, prev_done = 1'b0;
  logic [7:0] held_data = 8'h00;

  assign bus.mem_data  = mem[bus.mem_addr];
  assign bus.tx_active = uart_busy | force_busy;
  assign bus.tx_done   = tx_done_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference frame straight from the wire format: header, samples, XOR of samples.
  task automatic build_expected();
    logic [7:0] x;
    x = 8'h00;
    exp_frame[0] = 8'h22;
    for (int i = 0; i < 256; i++) begin
      exp_frame[i+1] = mem[i];
      x = x ^ mem[i];
    end
    exp_frame[FRAME_LEN-1] = x;
  endtask

  // UART transmitter: busy from tx_start until a one-cycle tx_done 10 cycles later.
  initial begin
    uart_busy = 1'b0;
    tx_done_r = 1'b0;
    late_seen = 1'b0;
    uart_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      tx_done_r = 1'b0;
      if (uart_cnt > 0) begin
        uart_cnt--;
        if (uart_cnt == 0) begin
          tx_done_r = 1'b1;
          uart_busy = 1'b0;
          late_seen = 1'b1;
        end
      end else if (bus.tx_start) begin
        uart_busy = 1'b1;
        uart_cnt  = 10;
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (bus.tx_start) begin
      check("tx_start_single_cycle", {31'd0, prev_start}, 32'd0);
      if (nbytes < FRAME_LEN) begin
        check("frame_byte", {24'd0, bus.tx_data}, {24'd0, exp_frame[nbytes]});
        cap[nbytes] = bus.tx_data;
        if (nbytes >= 1)
          check("tx_done_to_start_gap", cyc - last_done_cyc,
                (nbytes == FRAME_LEN - 1) ? 2 : 3);
      end else begin
        check("extra_byte_index", nbytes, FRAME_LEN - 1);
      end
      held_data = bus.tx_data;
      nbytes++;
      total_starts++;
    end
    if (bus.tx_done && bus.mem_oe)
      check("tx_data_hold", {24'd0, bus.tx_data}, {24'd0, held_data});
    if (done && !prev_done)
      check("done_latency", cyc - last_done_cyc, 2);
    if (bus.tx_done)
      last_done_cyc = cyc;
    prev_start = bus.tx_start;
    prev_done  = done;
  end

  task automatic start_frame(input bit expect_immediate);
    nbytes = 0;
    build_expected();
    @(negedge clk);
    activate = 1'b1;
    if (expect_immediate) begin
      @(negedge clk);
      check("start_no_pulse_yet", {31'd0, bus.tx_start}, 32'd0);
      check("start_mem_oe", {31'd0, bus.mem_oe}, 32'd1);
      @(negedge clk);
      check("start_pulse", {31'd0, bus.tx_start}, 32'd1);
      check("start_header", {24'd0, bus.tx_data}, 32'h22);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("frame_done", {31'd0, done}, 32'd1);
    check("byte_count", nbytes, FRAME_LEN);
  endtask

  task automatic wait_bytes(input int target);
    int n;
    n = 0;
    while (nbytes < target && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("reached_byte", nbytes, target);
  endtask

  initial begin
    int s;
    reset      = 1'b0;
    activate   = 1'b0;
    force_busy = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    repeat (3) @(negedge clk);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    check("rst_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
    check("rst_mem_oe", {31'd0, bus.mem_oe}, 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Ramp memory: 0x22, 0x00..0xFF, 0x00
    start_frame(1);
    wait_done();
    check("ramp_b1", {24'd0, cap[1]}, 32'h00);
    check("ramp_b256", {24'd0, cap[256]}, 32'hFF);
    check("ramp_csum", {24'd0, cap[257]}, 32'h00);
    check("ramp_mem_oe_off", {31'd0, bus.mem_oe}, 32'd0);

    // Level-high activate must not restart
    s = total_starts;
    repeat (100) @(negedge clk);
    check("no_restart_starts", total_starts, s);
    check("no_restart_done", {31'd0, done}, 32'd1);
    activate = 1'b0;
    @(negedge clk);
    check("done_cleared", {31'd0, done}, 32'd0);

    for (int i = 0; i < 256; i++) mem[i] = 8'hA5;
    start_frame(1);
    wait_done();
    check("a5_b100", {24'd0, cap[100]}, 32'hA5);
    check("a5_csum", {24'd0, cap[257]}, 32'h00);
    activate = 1'b0;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[7] = 8'h3C;
    start_frame(1);
    wait_done();
    check("m7_b8", {24'd0, cap[8]}, 32'h3C);
    check("m7_csum", {24'd0, cap[257]}, 32'h3C);
    activate = 1'b0;

    // Transmitter busy at start
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    force_busy = 1'b1;
    s = total_starts;
    start_frame(0);
    repeat (50) @(negedge clk);
    check("busy_no_start", total_starts, s);
    force_busy = 1'b0;
    @(negedge clk);
    check("busy_release_pulse", {31'd0, bus.tx_start}, 32'd1);
    check("busy_release_header", {24'd0, bus.tx_data}, 32'h22);
    @(negedge clk);
    check("busy_pulse_width", {31'd0, bus.tx_start}, 32'd0);
    wait_done();
    activate = 1'b0;

    // Abort after byte 100 while it is still on the line
    start_frame(1);
    wait_bytes(101);
    activate  = 1'b0;
    late_seen = 1'b0;
    s = total_starts;
    @(negedge clk);
    check("abort_mem_oe", {31'd0, bus.mem_oe}, 32'd0);
    repeat (30) @(negedge clk);
    check("abort_late_tx_done_seen", {31'd0, late_seen}, 32'd1);
    check("abort_no_start", total_starts, s);
    check("abort_done_low", {31'd0, done}, 32'd0);
    check("abort_tx_start_low", {31'd0, bus.tx_start}, 32'd0);

    // Asynchronous reset mid-frame
    start_frame(1);
    wait_bytes(20);
    @(negedge clk);
    #2;
    reset    = 1'b0;
    activate = 1'b0;
    #1;
    check("arst_tx_start", {31'd0, bus.tx_start}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_mem_oe", {31'd0, bus.mem_oe}, 32'd0);
    check("arst_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
    check("arst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    start_frame(1);
    wait_done();
    check("post_rst_csum", {24'd0, cap[257]}, 32'h00);
    check("post_rst_b255", {24'd0, cap[255]}, 32'hFE);
    activate = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
